// File: rtl/fifo_pkg.sv
// Constants shared by the FIFO and its read-side streamer so both agree on
// data width and pointer sizing.
package fifo_pkg;
    localparam int WIDTH      = 8;
    localparam int FIFO_SIZE  = 16;
    localparam int PTR_WIDTH  = $clog2(FIFO_SIZE);
    localparam int SKID_DEPTH = 2;
endpackage

// File: rtl/skid_buf2.sv
// Two-entry in-order buffer: push at tail, pop at head, no bypass from push
// to head, so a push into an empty buffer becomes visible one cycle later.
module skid_buf2
    import fifo_pkg::*;
#(
    parameter int WIDTH = fifo_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = din;
                else                 tail_d = din;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged; the surviving entry moves to head.
                if (count_q == 2'd1) begin
                    head_d = din;
                end else begin
                    head_d = tail_q;
                    tail_d = din;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign head  = head_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && count_q == 2'd2));
endmodule

// File: rtl/fifo_rd_streamer.sv
// FIFO read-side drain engine: issues reads only when the skid buffer can
// absorb them, streams the data out and frames it into PKT_LEN-beat packets.
module fifo_rd_streamer
    import fifo_pkg::*;
#(
    parameter int WIDTH      = fifo_pkg::WIDTH,
    parameter int PKT_LEN    = 4,
    parameter int CNT_WIDTH  = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1,
    parameter int PCNT_WIDTH = 16
) (
    input  logic                  rd_clk,
    input  logic                  res_n,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    input  logic [WIDTH-1:0]      fifo_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_last,
    output logic [PCNT_WIDTH-1:0] pkt_count,
    output logic                  err_underflow
);
    logic                  inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic [PCNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
    logic                  err_q, err_d;
    logic [1:0]            count;
    logic [2:0]            occ;
    logic                  pop;

    skid_buf2 #(.WIDTH(WIDTH)) u_skid (
        .clk   (rd_clk),
        .rst_n (res_n),
        .push  (inflight_q),
        .din   (fifo_rdata),
        .pop   (pop),
        .count (count),
        .head  (out_data)
    );

    always_comb begin
        out_valid = (count != 2'd0);
        pop       = out_valid && out_ready;
        occ       = {1'b0, count} + {2'b00, inflight_q};
        // A same-cycle pop frees a slot, which keeps one read per cycle going.
        fifo_rd_en = res_n && en && !fifo_empty &&
                     (occ < 3'(SKID_DEPTH) + {2'b00, pop});
        out_last   = out_valid && (beat_cnt_q == CNT_WIDTH'(PKT_LEN - 1));
        inflight_d = fifo_rd_en;
        beat_cnt_d = beat_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        if (pop) begin
            if (out_last) begin
                beat_cnt_d = '0;
                pkt_cnt_d  = pkt_cnt_q + 1'b1;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end
        err_d = err_q || fifo_underflow || (fifo_rd_en && fifo_empty);
    end

    always_ff @(posedge rd_clk or negedge res_n) begin
        if (!res_n) begin
            inflight_q <= 1'b0;
            beat_cnt_q <= '0;
            pkt_cnt_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            beat_cnt_q <= beat_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            err_q      <= err_d;
        end
    end

    assign pkt_count     = pkt_cnt_q;
    assign err_underflow = err_q;
endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Directed bench for fifo_rd_streamer: a behavioural FIFO feeds the DUT and a
// scoreboard checks every delivered beat's data and framing.
module tb_fifo_rd_streamer;
    localparam int W   = 8;
    localparam int PL  = 4;
    localparam int PCW = 16;

    logic           rd_clk = 1'b0;
    logic           res_n = 1'b0;
    logic           en = 1'b0;
    logic           fifo_empty = 1'b1;
    logic           fifo_underflow = 1'b0;
    logic           out_ready = 1'b0;
    logic [W-1:0]   fifo_rdata = '0;
    logic           fifo_rd_en, out_valid, out_last, err_underflow;
    logic [W-1:0]   out_data;
    logic [PCW-1:0] pkt_count;

    always #5 rd_clk = ~rd_clk;

    fifo_rd_streamer #(.WIDTH(W), .PKT_LEN(PL), .PCNT_WIDTH(PCW)) dut (
        .rd_clk         (rd_clk),
        .res_n          (res_n),
        .en             (en),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .fifo_rd_en     (fifo_rd_en),
        .fifo_rdata     (fifo_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last),
        .pkt_count      (pkt_count),
        .err_underflow  (err_underflow)
    );

    typedef struct packed {
        logic         last;
        logic [W-1:0] data;
    } exp_t;

    logic [W-1:0] fifo_q[$];
    exp_t         exp_q[$];
    int n_cmp = 0, n_err = 0;
    int rd_cnt = 0, pop_cnt = 0, exp_beat = 0, exp_pkt = 0;
    logic rd_en_s = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Writes land in the model FIFO and the expected-beat queue together.
    task automatic wr(input logic [W-1:0] d);
        exp_t e;
        e.data = d;
        e.last = (exp_beat == PL - 1);
        exp_beat = (exp_beat + 1) % PL;
        fifo_q.push_back(d);
        exp_q.push_back(e);
        fifo_empty = 1'b0;
    endtask

    // Sample on the falling edge, then update the FIFO model after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge rd_clk);
        rd_en_s = fifo_rd_en;
        chk("rd_on_empty", {31'd0, fifo_rd_en & fifo_empty}, 0);
        if (res_n && out_valid && out_ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
                chk("sb_extra_beat", 0, 1);
            end else begin
                e = exp_q.pop_front();
                chk("sb_data", {24'd0, out_data}, {24'd0, e.data});
                chk("sb_last", {31'd0, out_last}, {31'd0, e.last});
                if (e.last) exp_pkt++;
            end
        end
        @(posedge rd_clk);
        #1;
        if (rd_en_s) begin
            rd_cnt++;
            if (fifo_q.size() > 0) fifo_rdata = fifo_q.pop_front();
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    initial begin
        int r0, p0, k;
        #2;
        chk("rst_rd_en", {31'd0, fifo_rd_en}, 0);
        chk("rst_valid", {31'd0, out_valid}, 0);
        chk("rst_data", {24'd0, out_data}, 0);
        chk("rst_last", {31'd0, out_last}, 0);
        chk("rst_pkt", {16'd0, pkt_count}, 0);
        chk("rst_err", {31'd0, err_underflow}, 0);
        @(posedge rd_clk);
        #1;
        res_n = 1'b1;
        tick();

        // Full throughput: 8 beats, two packets.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) wr(8'h10 + 8'(i));
        p0 = pop_cnt;
        en = 1'b1;
        tick(); tick();
        chk("tp_latency", pop_cnt - p0, 0);
        repeat (8) tick();
        chk("tp_beats", pop_cnt - p0, 8);
        chk("tp_drained", exp_q.size(), 0);
        chk("tp_pkt", {16'd0, pkt_count}, 2);
        chk("tp_pkt_model", {16'd0, pkt_count}, exp_pkt);

        // Backpressure: reads stop once two beats are buffered or inflight.
        en = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) wr(8'hA0 + 8'(i));
        r0 = rd_cnt;
        en = 1'b1;
        k = 0;
        while (!out_valid && k < 10) begin tick(); k++; end
        chk("bp_valid", {31'd0, out_valid}, 1);
        repeat (5) begin
            tick();
            chk("bp_hold_data", {24'd0, out_data}, 32'hA0);
            chk("bp_hold_valid", {31'd0, out_valid}, 1);
        end
        chk("bp_rd_stop", rd_cnt - r0, 2);
        out_ready = 1'b1;
        repeat (8) tick();
        chk("bp_drained", exp_q.size(), 0);
        chk("bp_rd_total", rd_cnt - r0, 4);
        chk("bp_pkt", {16'd0, pkt_count}, 3);

        // Enable gating: drop en with one read inflight.
        en = 1'b0;
        for (int i = 0; i < 4; i++) wr(8'h33 + 8'(i));
        r0 = rd_cnt;
        en = 1'b1;
        tick();
        en = 1'b0;
        repeat (6) tick();
        chk("en_rd_once", rd_cnt - r0, 1);
        chk("en_one_beat", exp_q.size(), 3);
        chk("en_valid_low", {31'd0, out_valid}, 0);
        en = 1'b1;
        repeat (10) tick();
        chk("en_resume", exp_q.size(), 0);
        chk("en_pkt", {16'd0, pkt_count}, 4);

        // Empty protection, then a single write.
        r0 = rd_cnt;
        p0 = pop_cnt;
        repeat (5) tick();
        chk("emp_no_rd", rd_cnt - r0, 0);
        chk("emp_valid", {31'd0, out_valid}, 0);
        chk("emp_err", {31'd0, err_underflow}, 0);
        wr(8'h55);
        repeat (6) tick();
        chk("emp_one_rd", rd_cnt - r0, 1);
        chk("emp_one_beat", pop_cnt - p0, 1);
        chk("emp_drained", exp_q.size(), 0);

        // Reset in the middle of a packet, between clock edges.
        wr(8'h70);
        wr(8'h71);
        tick(); tick();
        chk("rst_mid_pre_valid", {31'd0, out_valid}, 1);
        #2 res_n = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, out_valid}, 0);
        chk("rst_mid_data", {24'd0, out_data}, 0);
        chk("rst_mid_last", {31'd0, out_last}, 0);
        chk("rst_mid_pkt", {16'd0, pkt_count}, 0);
        chk("rst_mid_rd_en", {31'd0, fifo_rd_en}, 0);
        fifo_q.delete();
        exp_q.delete();
        exp_beat = 0;
        exp_pkt = 0;
        fifo_empty = 1'b1;
        fifo_rdata = '0;
        tick();
        res_n = 1'b1;
        for (int i = 0; i < 4; i++) wr(8'h60 + 8'(i));
        repeat (10) tick();
        chk("rst_mid_drained", exp_q.size(), 0);
        chk("rst_mid_newpkt", {16'd0, pkt_count}, 1);

        // Underflow is sticky until reset.
        fifo_underflow = 1'b1;
        tick();
        fifo_underflow = 1'b0;
        chk("err_set", {31'd0, err_underflow}, 1);
        repeat (3) tick();
        chk("err_sticky", {31'd0, err_underflow}, 1);
        #2 res_n = 1'b0;
        #1;
        chk("err_cleared", {31'd0, err_underflow}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
